ram_access_arbiter: RTL

// - Shares the single-port SPI RAM command interface between NREQ requesters (SPI slave path, BIST/host).
// - Converts each granted request into the RAM two-phase command sequence:
//   - write: WR_ADDR (00), then WR_DATA (01).
//   - read:  RD_ADDR (10), then RD_DATA (11).
// - Waits for the RAM read response and returns it to the owner.
// - Sits between the requesters and the RAM's din/rx_valid/dout/tx_valid port; grants are round-robin.

---
 rtl/ram_access_arbiter_pkg.sv | 17 +
 rtl/ram_access_arbiter_rr_arbiter.sv | 35 +++
 rtl/ram_access_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared definitions for the RAM access arbiter: RAM command opcodes and FSM states.
package RAM_shared_pkg;

  // Opcodes carried in ram_din[9:8]
  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD1    = 2'd1,
    CMD2    = 2'd2,
    WAIT_RD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ram_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  int               sum;
  logic [IDX_W-1:0] idx;

  // First requester after the last owner wins; the last owner itself is checked last
  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDX_W'(sum);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        index       = idx;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port SPI RAM command port between NREQ requesters. Each granted
// request becomes a two-cycle command pair (address then data); reads then wait for
// the RAM response or a timeout before completing back to the owner.
module ram_access_arbiter
  import RAM_shared_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*ADDR_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [ADDR_W-1:0]        rdata,
  output logic [ADDR_W+1:0]        ram_din,
  output logic                     ram_rx_valid,
  input  logic [ADDR_W-1:0]        ram_dout,
  input  logic                     ram_tx_valid
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NREQ - 1);

  arb_state_e state, state_next;

  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [ADDR_W-1:0] wdata_l;
  logic [CNT_W-1:0]  cnt;
  logic              rd_done;
  logic              accept;
  logic              wr_done;
  logic              rd_ok;
  logic              rd_to;
  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [ADDR_W-1:0] wdata_arr [NREQ];

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_onehot),
    .index  (pick_idx),
    .found  (pick_found)
  );

  // Unpack the per-requester address/data buses so the winner can be indexed directly
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = wdata[i*ADDR_W +: ADDR_W];
    end
  end

  // Completion goes only to the owner; a write completes combinationally in CMD2
  assign done = (wr_done || rd_done) ? (NREQ'(1) << owner) : '0;

  // Next-state and strobe decode; grants are suppressed while reset is asserted
  always_comb begin
    state_next = state;
    gnt        = '0;
    accept     = 1'b0;
    wr_done    = 1'b0;
    rd_ok      = 1'b0;
    rd_to      = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && pick_found) begin
          accept     = 1'b1;
          gnt        = pick_onehot;
          state_next = CMD1;
        end
      end
      CMD1: state_next = CMD2;
      CMD2: begin
        if (we_l) begin
          wr_done    = rst_n;
          state_next = IDLE;
        end else begin
          state_next = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          rd_ok      = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_MAX) begin
          rd_to      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Latch the winning request; only loaded when a grant is issued
  always_ff @(posedge clk) begin
    if (accept) begin
      owner   <= pick_idx;
      we_l    <= we[pick_idx];
      addr_l  <= addr_arr[pick_idx];
      wdata_l <= wdata_arr[pick_idx];
    end
  end

  // RAM command register, RR pointer, timeout counter and read completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr          <= PTR_RST;
      cnt          <= '0;
      rd_done      <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      rd_done <= rd_ok || rd_to;
      err     <= rd_to;
      if (accept) begin
        ptr          <= pick_idx;
        ram_rx_valid <= 1'b1;
        ram_din      <= {we[pick_idx] ? WR_ADDR : RD_ADDR, addr_arr[pick_idx]};
      end else if (state == CMD1) begin
        ram_rx_valid <= 1'b1;
        ram_din      <= {we_l ? WR_DATA : RD_DATA, we_l ? wdata_l : {ADDR_W{1'b0}}};
      end else begin
        ram_rx_valid <= 1'b0;
      end
      if (state == CMD2) begin
        cnt <= '0;
      end else if (state == WAIT_RD && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (rd_ok) begin
        rdata <= ram_dout;
      end else if (rd_to) begin
        rdata <= '0;
      end
    end
  end

endmodule
